// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer
//   Request front-end for the QSPI flash controller (LLC). Queues word-level
//   read / program / erase requests in a small FIFO and issues them one at a
//   time on the LLC command port. Address-sequential quad reads are chained
//   with o_llc_op_cont so the controller keeps CS low across words. Exactly one
//   response is returned per request; each LLC operation has a timeout.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req_*, o_req_ready  request handshake (cmd 00 read, 01 program, 10 erase, 11 reserved)
//   o_rsp_*, i_rsp_ready  response handshake (rdata, err)
//   o_llc_*               command to the LLC, held stable while o_llc_write=1
//   i_llc_word/valid/busy completion data, one-cycle done pulse, busy flag
//   o_idle                FIFO empty and sequencer idle
module flash_cmd_sequencer #(
   parameter int FIFO_DEPTH  = 4,
   parameter int BURST_MAX   = 16,
   parameter int TIMEOUT_CYC = 1048576
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [1:0]  i_req_cmd,
   input  logic [23:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic        i_req_quad,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_llc_write,
   output logic        o_llc_op_cont,
   output logic [23:0] o_llc_address,
   output logic [31:0] o_llc_word,
   output logic        o_llc_spd,
   output logic        o_llc_dir,
   output logic        o_llc_erase,
   input  logic [31:0] i_llc_word,
   input  logic        i_llc_valid,
   input  logic        i_llc_busy,
   output logic        o_idle
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int BW = $clog2(BURST_MAX + 1);

   typedef struct packed {
      logic [1:0]  cmd;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic        quad;
   } req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   req_t          mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [CW-1:0] count;
   logic          live;      // low during reset so ready/idle read 0 there
   state_t        state;
   logic [TW-1:0] tcnt;
   logic [BW-1:0] bcnt;      // words already chained in the current burst
   logic          burst_q;   // previous op was issued with op_cont=1

   req_t head;
   logic full, has_head, has_next, push, pop;
   logic go, do_rsvd, do_issue, cont_ok, busy_ok;

   assign head     = mem[rd_ptr];
   assign rd_nxt   = rd_ptr + AW'(1);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign has_head = (count != '0);
   assign has_next = (count > CW'(1));

   assign o_req_ready = live & ~full;
   assign o_idle      = live & ~has_head & (state == IDLE);
   assign push        = i_req_valid & o_req_ready;

   // Chain only when the following queued word continues the same quad read.
   assign cont_ok = (head.cmd == 2'b00) && head.quad && has_next &&
                    (mem[rd_nxt].cmd == 2'b00) && mem[rd_nxt].quad &&
                    (mem[rd_nxt].addr == head.addr + 24'd4) &&
                    ((32'(bcnt) + 32'd1) < 32'(BURST_MAX));

   // Inside a burst the LLC stays busy with CS held low, so busy is not a gate.
   assign busy_ok = ~i_llc_busy | burst_q;

   // Dispatch happens straight from IDLE and from an accepted response so the
   // head issues without an extra cycle; ISSUE only holds while busy blocks it.
   assign go       = has_head & ((state == IDLE) | (state == ISSUE) |
                                 ((state == RESP) & i_rsp_ready));
   assign do_rsvd  = go & (head.cmd == 2'b11);
   assign do_issue = go & (head.cmd != 2'b11) & busy_ok;
   assign pop      = do_rsvd | do_issue;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_nxt;
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= '{cmd: i_req_cmd, addr: i_req_addr, wdata: i_req_wdata, quad: i_req_quad};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         live          <= 1'b0;
         state         <= IDLE;
         tcnt          <= '0;
         bcnt          <= '0;
         burst_q       <= 1'b0;
         o_llc_write   <= 1'b0;
         o_llc_op_cont <= 1'b0;
         o_llc_address <= '0;
         o_llc_word    <= '0;
         o_llc_spd     <= 1'b0;
         o_llc_dir     <= 1'b0;
         o_llc_erase   <= 1'b0;
         o_rsp_valid   <= 1'b0;
         o_rsp_rdata   <= '0;
         o_rsp_err     <= 1'b0;
      end else begin
         live <= 1'b1;
         case (state)
            IDLE, ISSUE: if (has_head) state <= ISSUE;
            WAIT: begin
               // a completion in the timeout cycle wins over the error
               if (i_llc_valid) begin
                  o_llc_write <= 1'b0;
                  o_rsp_valid <= 1'b1;
                  o_rsp_err   <= 1'b0;
                  o_rsp_rdata <= o_llc_dir ? 32'h0 : i_llc_word;
                  state       <= RESP;
               end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                  o_llc_write   <= 1'b0;
                  o_llc_op_cont <= 1'b0;
                  o_rsp_valid   <= 1'b1;
                  o_rsp_err     <= 1'b1;
                  o_rsp_rdata   <= 32'h0;
                  burst_q       <= 1'b0;
                  bcnt          <= '0;
                  state         <= RESP;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            RESP: if (i_rsp_ready) begin
               o_rsp_valid <= 1'b0;
               state       <= has_head ? ISSUE : IDLE;
            end
            default: state <= IDLE;
         endcase

         if (do_rsvd) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= 32'h0;
            state       <= RESP;
         end

         if (do_issue) begin
            o_llc_write   <= 1'b1;
            o_llc_op_cont <= cont_ok;
            o_llc_address <= head.addr;
            o_llc_word    <= head.wdata;
            o_llc_spd     <= head.quad;
            o_llc_dir     <= (head.cmd != 2'b00);
            o_llc_erase   <= (head.cmd == 2'b10);
            burst_q       <= cont_ok;
            bcnt          <= cont_ok ? bcnt + BW'(1) : '0;
            tcnt          <= '0;
            state         <= WAIT;
         end
      end
   end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer
//   Scoreboarded bench for flash_cmd_sequencer: expected LLC ops and responses
//   are queued when requests are driven; an LLC model and a response sink pop
//   and compare them as the DUT produces them.
module tb_flash_cmd_sequencer;

   localparam int TO = 64;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [1:0]  i_req_cmd;
   logic [23:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic        i_req_quad;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic        o_llc_write;
   logic        o_llc_op_cont;
   logic [23:0] o_llc_address;
   logic [31:0] o_llc_word;
   logic        o_llc_spd;
   logic        o_llc_dir;
   logic        o_llc_erase;
   logic [31:0] i_llc_word;
   logic        i_llc_valid;
   logic        i_llc_busy;
   logic        o_idle;

   logic busy_force = 1'b0;
   logic mdl_busy   = 1'b0;
   assign i_llc_busy = busy_force | mdl_busy;

   flash_cmd_sequencer #(.FIFO_DEPTH(4), .BURST_MAX(16), .TIMEOUT_CYC(TO)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_cmd(i_req_cmd),
      .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_quad(i_req_quad),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
      .o_rsp_err(o_rsp_err), .o_llc_write(o_llc_write), .o_llc_op_cont(o_llc_op_cont),
      .o_llc_address(o_llc_address), .o_llc_word(o_llc_word), .o_llc_spd(o_llc_spd),
      .o_llc_dir(o_llc_dir), .o_llc_erase(o_llc_erase), .i_llc_word(i_llc_word),
      .i_llc_valid(i_llc_valid), .i_llc_busy(i_llc_busy), .o_idle(o_idle)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   typedef struct packed {
      logic [23:0] addr;
      logic [31:0] word;
      logic        cont;
      logic        spd;
      logic        dir;
      logic        erase;
      logic        mute;   // LLC model never answers this op
   } op_t;

   rsp_t exp_rsp_q[$];
   op_t  exp_op_q[$];

   int checks   = 0;
   int failures = 0;

   int   lat         = 3;
   logic rsp_hold    = 1'b0;
   logic rst_abort   = 1'b0;
   logic stray_req   = 1'b0;
   int   rsp_acc_cyc = -10;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] llc_data(input logic [23:0] a);
      if (a == 24'h00F000) return 32'hA5A5A5A5;
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic send_req(input logic [1:0] cmd, input logic [23:0] addr, input logic [31:0] wdata,
                           input logic quad, input logic cont, input logic mute);
      rsp_t r;
      op_t  o;
      int   n;
      r.err   = (cmd == 2'b11) || mute;
      r.rdata = (cmd == 2'b00 && !r.err) ? llc_data(addr) : 32'h0;
      exp_rsp_q.push_back(r);
      if (cmd != 2'b11) begin
         o.addr = addr; o.word = wdata; o.cont = cont; o.spd = quad;
         o.dir = (cmd != 2'b00); o.erase = (cmd == 2'b10); o.mute = mute;
         exp_op_q.push_back(o);
      end
      i_req_valid = 1'b1; i_req_cmd = cmd; i_req_addr = addr;
      i_req_wdata = wdata; i_req_quad = quad;
      n = 0;
      while (!o_req_ready && n < 500) begin
         @(posedge i_clk); #1; n++;
      end
      chk("req_accept", o_req_ready, 1);
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget && exp_rsp_q.size() != 0; i++) begin
         @(posedge i_clk); #1;
      end
      chk(tag, exp_rsp_q.size(), 0);
      repeat (8) @(posedge i_clk);
      #1;
   endtask

   // LLC model: checks each issued op against the scoreboard, answers after
   // lat cycles, stays busy for a tail after a non-chained op.
   op_t         cur;
   logic        wr_q = 1'b0, last_cont = 1'b0, pending = 1'b0, vflag = 1'b0, busy_seen;
   int          latc = 0, wcnt = 0, tail = 0;
   logic [59:0] snap;

   initial begin
      i_llc_valid = 1'b0;
      i_llc_word  = 32'h0;
      cur         = '0;
      forever begin
         @(posedge i_clk);
         busy_seen = i_llc_busy;
         #1;
         i_llc_valid = 1'b0;
         if (vflag) begin
            chk("valid_to_rsp", {o_rsp_valid, o_llc_write}, 2'b10);
            vflag = 1'b0;
         end
         if (o_llc_write && !wr_q) begin
            chk("op_expected", exp_op_q.size() != 0, 1);
            if (exp_op_q.size() != 0) cur = exp_op_q.pop_front();
            else begin cur = '0; cur.mute = 1'b1; end
            chk("llc_addr",  o_llc_address, cur.addr);
            chk("llc_word",  o_llc_word,    cur.word);
            chk("llc_cont",  o_llc_op_cont, cur.cont);
            chk("llc_spd",   o_llc_spd,     cur.spd);
            chk("llc_dir",   o_llc_dir,     cur.dir);
            chk("llc_erase", o_llc_erase,   cur.erase);
            if (last_cont) chk("burst_r1", cyc, rsp_acc_cyc + 1);
            else           chk("busy_gate", busy_seen, 0);
            last_cont = o_llc_op_cont;
            mdl_busy  = 1'b1;
            tail      = 0;
            pending   = !cur.mute;
            latc      = lat;
            wcnt      = 0;
            snap      = {o_llc_address, o_llc_word, o_llc_op_cont, o_llc_spd, o_llc_dir, o_llc_erase};
         end else if (o_llc_write) begin
            chk("llc_stable", {o_llc_address, o_llc_word, o_llc_op_cont, o_llc_spd, o_llc_dir, o_llc_erase}, snap);
         end
         if (o_llc_write) begin
            wcnt++;
            if (pending) begin
               if (latc == 0) begin
                  i_llc_valid = 1'b1;
                  i_llc_word  = cur.dir ? 32'hDEADBEEF : llc_data(cur.addr);
                  pending     = 1'b0;
                  vflag       = 1'b1;
               end else latc--;
            end
         end
         if (!o_llc_write && wr_q) begin
            if (rst_abort) begin
               mdl_busy = 1'b0; last_cont = 1'b0; pending = 1'b0;
            end else if (cur.mute) begin
               chk("to_len", wcnt, TO);
               mdl_busy = 1'b0; last_cont = 1'b0;
            end else if (!last_cont) tail = 4;
         end
         if (tail > 0) begin
            tail--;
            if (tail == 0) mdl_busy = 1'b0;
         end
         if (stray_req && !o_llc_write) begin
            i_llc_valid = 1'b1;
            i_llc_word  = 32'h12345678;
            stray_req   = 1'b0;
         end
         wr_q = o_llc_write;
      end
   end

   // Response sink
   logic        hold_q = 1'b0;
   logic [33:0] rsnap;
   rsp_t        er;
   initial begin
      i_rsp_ready = 1'b0;
      forever begin
         @(posedge i_clk); #1;
         if (hold_q && !rst_abort) chk("rsp_stable", {o_rsp_valid, o_rsp_err, o_rsp_rdata}, rsnap);
         i_rsp_ready = !rsp_hold;
         if (o_rsp_valid && i_rsp_ready) begin
            chk("rsp_expected", exp_rsp_q.size() != 0, 1);
            if (exp_rsp_q.size() != 0) begin
               er = exp_rsp_q.pop_front();
               chk("rsp_rdata", o_rsp_rdata, er.rdata);
               chk("rsp_err",   o_rsp_err,   er.err);
            end
            rsp_acc_cyc = cyc;
         end
         hold_q = o_rsp_valid && !i_rsp_ready;
         rsnap  = {o_rsp_valid, o_rsp_err, o_rsp_rdata};
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      i_reset = 1'b1; i_req_valid = 1'b0; i_req_cmd = 2'b00;
      i_req_addr = 24'h0; i_req_wdata = 32'h0; i_req_quad = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_ctl", {o_req_ready, o_idle, o_rsp_valid, o_rsp_err, o_llc_write,
                      o_llc_op_cont, o_llc_spd, o_llc_dir, o_llc_erase}, 9'h0);
      chk("rst_addr", o_llc_address, 0);
      i_reset = 1'b0;
      @(posedge i_clk); #1;
      chk("post_rst_ready", o_req_ready, 1);
      chk("post_rst_idle",  o_idle, 1);

      // single quad read with slow LLC; issue latency from accept
      lat = 40;
      send_req(2'b00, 24'h00F000, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("issue_t1", o_llc_write, 0);
      @(posedge i_clk); #1;
      chk("issue_t2", o_llc_write, 1);
      wait_drain("drain_single", 200);
      lat = 3;

      // completion pulse while nothing is outstanding
      stray_req = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      chk("stray_rsp",  o_rsp_valid, 0);
      chk("stray_idle", o_idle, 1);

      // four queued sequential quad reads chain 1,1,1,0
      busy_force = 1'b1;
      for (int i = 0; i < 4; i++)
         send_req(2'b00, 24'h0AA000 + 24'(4 * i), 32'h0, 1'b1, i < 3, 1'b0);
      busy_force = 1'b0;
      wait_drain("drain_burst4", 200);

      // 20 sequential reads across the 24-bit wrap: chain breaks at word 16
      busy_force = 1'b1;
      fork
         begin
            repeat (10) @(posedge i_clk);
            #1;
            busy_force = 1'b0;
         end
      join_none
      for (int k = 1; k <= 20; k++)
         send_req(2'b00, 24'hFFFFF8 + 24'(4 * (k - 1)), 32'h0, 1'b1, (k != 16) && (k != 20), 1'b0);
      wait_drain("drain_burst20", 500);

      // erase then program, second waits for busy to drop
      send_req(2'b10, 24'h00F000, 32'h0, 1'b0, 1'b0, 1'b0);
      send_req(2'b01, 24'h00F000, 32'd67, 1'b0, 1'b0, 1'b0);
      wait_drain("drain_erase_prog", 200);

      // silent LLC times out; queued request proceeds normally
      send_req(2'b00, 24'h002000, 32'h0, 1'b1, 1'b0, 1'b1);
      send_req(2'b00, 24'h002100, 32'h0, 1'b1, 1'b0, 1'b0);
      wait_drain("drain_timeout", 400);

      // reserved command plus full FIFO while responses are held off
      rsp_hold = 1'b1;
      send_req(2'b11, 24'h123456, 32'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         send_req(2'b00, 24'h300000 + 24'(8 * i), 32'h0, 1'b0, 1'b0, 1'b0);
      chk("full_ready", o_req_ready, 0);
      chk("rsvd_hold", {o_rsp_valid, o_rsp_err, o_llc_write}, 3'b110);
      rsp_hold = 1'b0;
      wait_drain("drain_rsvd_full", 400);

      // reset during WAIT discards the op and the queued request
      send_req(2'b00, 24'h400000, 32'h0, 1'b1, 1'b0, 1'b1);
      send_req(2'b00, 24'h400010, 32'h0, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (!o_llc_write && n < 50) begin
         @(posedge i_clk); #1; n++;
      end
      chk("pre_rst_write", o_llc_write, 1);
      repeat (3) @(posedge i_clk);
      #1;
      rst_abort = 1'b1;
      i_reset   = 1'b1;
      @(posedge i_clk); #1;
      chk("abort_write", o_llc_write, 0);
      chk("abort_ctl", {o_req_ready, o_idle, o_rsp_valid, o_rsp_err, o_llc_write,
                        o_llc_op_cont, o_llc_spd, o_llc_dir, o_llc_erase}, 9'h0);
      chk("abort_addr",  o_llc_address, 0);
      chk("abort_word",  o_llc_word, 0);
      chk("abort_rdata", o_rsp_rdata, 0);
      exp_op_q.delete();
      exp_rsp_q.delete();
      i_reset = 1'b0;
      @(posedge i_clk); #1;
      chk("abort_ready", o_req_ready, 1);
      chk("abort_idle",  o_idle, 1);
      repeat (2) @(posedge i_clk);
      #1;
      rst_abort = 1'b0;

      send_req(2'b00, 24'h00F000, 32'h0, 1'b1, 1'b0, 1'b0);
      wait_drain("drain_after_rst", 200);
      chk("ops_left", exp_op_q.size(), 0);
      chk("final_idle", o_idle, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
